// File: rtl/hdmi_tmds_video_core_pkg.sv
// Shared TMDS constants, slot classification and code lookup helpers
// for the HDMI/DVI transmit core.
package hdmi_pkg;

  localparam logic [9:0] CTL_CODE_00 = 10'b1101010100;
  localparam logic [9:0] CTL_CODE_01 = 10'b0010101011;
  localparam logic [9:0] CTL_CODE_10 = 10'b0101010100;
  localparam logic [9:0] CTL_CODE_11 = 10'b1010101011;

  localparam logic [9:0] GUARD_CH0 = 10'b1011001100;
  localparam logic [9:0] GUARD_CH1 = 10'b0100110011;
  localparam logic [9:0] GUARD_CH2 = 10'b1011001100;

  localparam int PREAMBLE_LEN = 8;
  localparam int GUARD_LEN    = 2;

  // {CTL3,CTL2,CTL1,CTL0} during the video preamble
  localparam logic [3:0] PREAMBLE_CTL = 4'b0001;

  typedef enum logic [1:0] {CONTROL, PREAMBLE, GUARD, VIDEO} slot_t;

  function automatic logic [9:0] ctl_code(input logic [1:0] c);
    case (c)
      2'b00:   return CTL_CODE_00;
      2'b01:   return CTL_CODE_01;
      2'b10:   return CTL_CODE_10;
      default: return CTL_CODE_11;
    endcase
  endfunction

  function automatic logic [9:0] guard_code(input int ch);
    case (ch)
      0:       return GUARD_CH0;
      1:       return GUARD_CH1;
      default: return GUARD_CH2;
    endcase
  endfunction

endpackage

// File: rtl/hdmi_tmds_video_core_if.sv
// Pixel request / video data / TMDS symbol bundle between frame source,
// transmit core and serialiser.
interface hdmi_tmds_video_core_if #(
  parameter int VIDEO_DEPTH = 8,
  parameter int X_W         = 11,
  parameter int Y_W         = 10
);
  logic [3*VIDEO_DEPTH-1:0] VIDDATA;
  logic                     PIXEL_REQ;
  logic [X_W-1:0]           X;
  logic [Y_W-1:0]           Y;
  logic                     FRAME_START;
  logic [29:0]              TMDS_SYMBOLS;

  modport master (
    output VIDDATA,
    input  PIXEL_REQ, X, Y, FRAME_START, TMDS_SYMBOLS
  );

  modport slave (
    input  VIDDATA,
    output PIXEL_REQ, X, Y, FRAME_START, TMDS_SYMBOLS
  );
endinterface

// File: rtl/hdmi_tmds_video_core_tmds_encoder.sv
// One TMDS channel: DVI 8b/10b video encoding with running disparity,
// control/preamble codes and guard band, registered output.
module tmds_encoder
  import hdmi_pkg::*;
#(
  parameter logic [9:0] GUARD_CODE = GUARD_CH0,
  parameter logic [9:0] RST_CODE   = CTL_CODE_00
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [7:0] i_data,
  input  logic [1:0] i_ctrl,
  input  slot_t      i_slot,
  output logic [9:0] o_symbol
);

  function automatic logic [3:0] ones(input logic [7:0] d);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) n = n + {3'b000, d[i]};
    return n;
  endfunction

  function automatic logic [8:0] min_trans(input logic [7:0] d);
    logic [8:0] q;
    logic       use_xnor;
    logic [3:0] n;
    n        = ones(d);
    use_xnor = (n > 4'd4) || ((n == 4'd4) && !d[0]);
    q[0]     = d[0];
    for (int i = 1; i < 8; i++) q[i] = use_xnor ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
    q[8]     = ~use_xnor;
    return q;
  endfunction

  logic [8:0]        w_qm;
  logic [3:0]        w_n1;
  logic [3:0]        w_n0;
  logic signed [4:0] w_diff;
  logic signed [4:0] w_disp_next;
  logic signed [4:0] r_disp;
  logic [9:0]        w_sym;
  logic [9:0]        r_sym;

  assign w_qm   = min_trans(i_data);
  assign w_n1   = ones(w_qm[7:0]);
  assign w_n0   = 4'd8 - w_n1;
  assign w_diff = $signed({1'b0, w_n1}) - $signed({1'b0, w_n0});

  // Non-video slots restart the disparity from zero
  always_comb begin
    w_sym       = ctl_code(i_ctrl);
    w_disp_next = '0;
    case (i_slot)
      GUARD: w_sym = GUARD_CODE;
      VIDEO: begin
        if ((r_disp == 5'sd0) || (w_n1 == w_n0)) begin
          w_sym       = {~w_qm[8], w_qm[8], w_qm[8] ? w_qm[7:0] : ~w_qm[7:0]};
          w_disp_next = w_qm[8] ? (r_disp + w_diff) : (r_disp - w_diff);
        end else if (((r_disp > 5'sd0) && (w_n1 > w_n0)) ||
                     ((r_disp < 5'sd0) && (w_n0 > w_n1))) begin
          w_sym       = {1'b1, w_qm[8], ~w_qm[7:0]};
          w_disp_next = r_disp + (w_qm[8] ? 5'sd2 : 5'sd0) - w_diff;
        end else begin
          w_sym       = {1'b0, w_qm[8], w_qm[7:0]};
          w_disp_next = r_disp - (w_qm[8] ? 5'sd0 : 5'sd2) + w_diff;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_disp <= '0;
      r_sym  <= RST_CODE;
    end else begin
      r_disp <= w_disp_next;
      r_sym  <= w_sym;
    end
  end

  assign o_symbol = r_sym;

endmodule

// File: rtl/hdmi_tmds_video_core.sv
// Raster timing, pixel requests and three TMDS channels with optional
// HDMI video preamble / guard band framing.
module hdmi_tmds_video_core
  import hdmi_pkg::*;
#(
  parameter int H_ACTIVE    = 1280,
  parameter int H_FRONT     = 110,
  parameter int H_SYNC      = 40,
  parameter int H_BACK      = 220,
  parameter int V_ACTIVE    = 720,
  parameter int V_FRONT     = 5,
  parameter int V_SYNC      = 5,
  parameter int V_BACK      = 20,
  parameter int HSYNC_POL   = 1,
  parameter int VSYNC_POL   = 1,
  parameter int DVI_ONLY    = 0,
  parameter int VIDEO_DEPTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  hdmi_tmds_video_core_if.slave vid
);

  localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);
  localparam int XW = $clog2(H_ACTIVE);
  localparam int YW = $clog2(V_ACTIVE);

  localparam logic [HW-1:0] H_ACT_C  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] H_SS_C   = HW'(H_ACTIVE + H_FRONT);
  localparam logic [HW-1:0] H_SE_C   = HW'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [HW-1:0] H_PRE_C  = HW'(H_TOTAL - PREAMBLE_LEN - GUARD_LEN);
  localparam logic [HW-1:0] H_GRD_C  = HW'(H_TOTAL - GUARD_LEN);
  localparam logic [HW-1:0] H_LAST_C = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT_C  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] V_ACTM1_C = VW'(V_ACTIVE - 1);
  localparam logic [VW-1:0] V_SS_C   = VW'(V_ACTIVE + V_FRONT);
  localparam logic [VW-1:0] V_SE_C   = VW'(V_ACTIVE + V_FRONT + V_SYNC);
  localparam logic [VW-1:0] V_LAST_C = VW'(V_TOTAL - 1);
  localparam logic HS_IDLE = (HSYNC_POL == 0);
  localparam logic VS_IDLE = (VSYNC_POL == 0);
  localparam logic HDMI_EN = (DVI_ONLY == 0);

  if (H_FRONT + H_SYNC + H_BACK < 12) begin : g_bad_hblank
    $error("horizontal blanking must be at least 12 pixels");
  end
  if ((VIDEO_DEPTH < 1) || (VIDEO_DEPTH > 8)) begin : g_bad_depth
    $error("VIDEO_DEPTH must be in 1..8");
  end

  logic [HW-1:0] r_h;
  logic [VW-1:0] r_v;
  logic          w_active, w_hs, w_vs, w_pre_line;
  slot_t         w_slot;
  logic          r0_req, r0_fs, r0_hs, r0_vs;
  logic [XW-1:0] r0_x;
  logic [YW-1:0] r0_y;
  slot_t         r0_slot, r1_slot;
  logic          r1_hs, r1_vs;
  logic [1:0]    w_ctrl [3];
  logic [9:0]    w_sym  [3];

  assign w_active = (r_h < H_ACT_C) && (r_v < V_ACT_C);
  assign w_hs     = (r_h >= H_SS_C) && (r_h < H_SE_C);
  assign w_vs     = (r_v >= V_SS_C) && (r_v < V_SE_C);
  // The line that follows this one is active, so it carries the preamble
  assign w_pre_line = (r_v == V_LAST_C) || (r_v < V_ACTM1_C);

  always_comb begin
    w_slot = CONTROL;
    if (w_active)                                     w_slot = VIDEO;
    else if (HDMI_EN && w_pre_line && (r_h >= H_GRD_C)) w_slot = GUARD;
    else if (HDMI_EN && w_pre_line && (r_h >= H_PRE_C)) w_slot = PREAMBLE;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_h     <= '0;
      r_v     <= '0;
      r0_req  <= 1'b0;
      r0_fs   <= 1'b0;
      r0_x    <= '0;
      r0_y    <= '0;
      r0_slot <= CONTROL;
      r0_hs   <= HS_IDLE;
      r0_vs   <= VS_IDLE;
      r1_slot <= CONTROL;
      r1_hs   <= HS_IDLE;
      r1_vs   <= VS_IDLE;
    end else begin
      if (r_h == H_LAST_C) begin
        r_h <= '0;
        r_v <= (r_v == V_LAST_C) ? '0 : r_v + 1'b1;
      end else begin
        r_h <= r_h + 1'b1;
      end
      r0_req  <= w_active;
      r0_fs   <= (r_h == '0) && (r_v == '0);
      if (w_active) begin
        r0_x <= r_h[XW-1:0];
        r0_y <= r_v[YW-1:0];
      end
      r0_slot <= w_slot;
      r0_hs   <= (HSYNC_POL != 0) ? w_hs : ~w_hs;
      r0_vs   <= (VSYNC_POL != 0) ? w_vs : ~w_vs;
      r1_slot <= r0_slot;
      r1_hs   <= r0_hs;
      r1_vs   <= r0_vs;
    end
  end

  always_comb begin
    w_ctrl[0] = {r1_vs, r1_hs};
    w_ctrl[1] = (r1_slot == PREAMBLE) ? PREAMBLE_CTL[1:0] : 2'b00;
    w_ctrl[2] = (r1_slot == PREAMBLE) ? PREAMBLE_CTL[3:2] : 2'b00;
  end

  genvar gi, gj;
  for (gi = 0; gi < 3; gi++) begin : g_ch
    logic [VIDEO_DEPTH-1:0] w_comp;
    logic [7:0]             w_comp8;
    assign w_comp = vid.VIDDATA[gi*VIDEO_DEPTH +: VIDEO_DEPTH];
    // Left-justify and refill the low bits with the MSBs so full scale is 8'hFF
    for (gj = 0; gj < 8; gj++) begin : g_pad
      assign w_comp8[7-gj] = w_comp[VIDEO_DEPTH-1-(gj % VIDEO_DEPTH)];
    end
    tmds_encoder #(
      .GUARD_CODE (guard_code(gi)),
      .RST_CODE   ((gi == 0) ? ctl_code({VS_IDLE, HS_IDLE}) : CTL_CODE_00)
    ) u_enc (
      .CLK      (CLK),
      .RST      (RST),
      .i_data   (w_comp8),
      .i_ctrl   (w_ctrl[gi]),
      .i_slot   (r1_slot),
      .o_symbol (w_sym[gi])
    );
  end

  assign vid.PIXEL_REQ    = r0_req;
  assign vid.FRAME_START  = r0_fs;
  assign vid.X            = r0_x;
  assign vid.Y            = r0_y;
  assign vid.TMDS_SYMBOLS = {w_sym[2], w_sym[1], w_sym[0]};

endmodule

// File: tb/tb_hdmi_tmds_video_core.sv
// Directed bench: small 20x8 raster in HDMI, DVI and 5-bit-depth builds,
// checked cycle by cycle against hand-encoded symbol tables.
module tb_hdmi_tmds_video_core;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  logic prev_req [3];

  // Hand-encoded 8-pixel runs starting from zero disparity
  logic [9:0] t00 [8] = '{10'h100, 10'h3FF, 10'h100, 10'h3FF, 10'h100, 10'h3FF, 10'h100, 10'h3FF};
  logic [9:0] tff [8] = '{10'h200, 10'h0FF, 10'h0FF, 10'h200, 10'h0FF, 10'h200, 10'h0FF, 10'h200};
  logic [9:0] t84 [8] = '{10'h17C, 10'h383, 10'h383, 10'h383, 10'h383, 10'h383, 10'h383, 10'h383};

  hdmi_tmds_video_core_if #(.VIDEO_DEPTH(8), .X_W(3), .Y_W(2)) if_h ();
  hdmi_tmds_video_core_if #(.VIDEO_DEPTH(8), .X_W(3), .Y_W(2)) if_d ();
  hdmi_tmds_video_core_if #(.VIDEO_DEPTH(5), .X_W(3), .Y_W(2)) if_5 ();

  hdmi_tmds_video_core #(
    .H_ACTIVE(8), .H_FRONT(2), .H_SYNC(2), .H_BACK(8),
    .V_ACTIVE(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(2),
    .HSYNC_POL(1), .VSYNC_POL(1), .DVI_ONLY(0), .VIDEO_DEPTH(8)
  ) dut_h (.CLK(clk), .RST(rst), .vid(if_h));

  hdmi_tmds_video_core #(
    .H_ACTIVE(8), .H_FRONT(2), .H_SYNC(2), .H_BACK(8),
    .V_ACTIVE(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(2),
    .HSYNC_POL(1), .VSYNC_POL(1), .DVI_ONLY(1), .VIDEO_DEPTH(8)
  ) dut_d (.CLK(clk), .RST(rst), .vid(if_d));

  hdmi_tmds_video_core #(
    .H_ACTIVE(8), .H_FRONT(2), .H_SYNC(2), .H_BACK(8),
    .V_ACTIVE(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(2),
    .HSYNC_POL(1), .VSYNC_POL(1), .DVI_ONLY(0), .VIDEO_DEPTH(5)
  ) dut_5 (.CLK(clk), .RST(rst), .vid(if_5));

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [9:0] ctl(input logic vs, input logic hs);
    case ({vs, hs})
      2'b00:   return 10'h354;
      2'b01:   return 10'h0AB;
      2'b10:   return 10'h154;
      default: return 10'h2AB;
    endcase
  endfunction

  // kind: 0 = HDMI 8-bit, 1 = DVI 8-bit, 2 = HDMI 5-bit
  function automatic logic [29:0] exp_sym(input int kind, input int c);
    int s, h, v;
    logic [9:0] c0, c1, c2;
    if (c < 2) return {3{10'h354}};
    s  = c - 2;
    h  = s % 20;
    v  = (s / 20) % 8;
    c0 = ctl(v == 5, (h >= 10) && (h < 12));
    c1 = 10'h354;
    c2 = 10'h354;
    if ((h < 8) && (v < 4)) begin
      c0 = t00[h];
      c1 = (kind == 2) ? t84[h] : t00[h];
      c2 = tff[h];
    end else if ((kind != 1) && ((v == 7) || (v < 3))) begin
      if ((h >= 10) && (h <= 17)) begin
        c1 = 10'h0AB;
      end else if (h >= 18) begin
        c0 = 10'h2CC;
        c1 = 10'h133;
        c2 = 10'h2CC;
      end
    end
    return {c2, c1, c0};
  endfunction

  task automatic sample(input int kind, output logic req, output logic fs,
                        output logic [2:0] x, output logic [1:0] y, output logic [29:0] sym);
    case (kind)
      0: begin req = if_h.PIXEL_REQ; fs = if_h.FRAME_START; x = if_h.X; y = if_h.Y; sym = if_h.TMDS_SYMBOLS; end
      1: begin req = if_d.PIXEL_REQ; fs = if_d.FRAME_START; x = if_d.X; y = if_d.Y; sym = if_d.TMDS_SYMBOLS; end
      default: begin req = if_5.PIXEL_REQ; fs = if_5.FRAME_START; x = if_5.X; y = if_5.Y; sym = if_5.TMDS_SYMBOLS; end
    endcase
  endtask

  task automatic check_dut(input int kind, input int c);
    logic req, fs, exp_req;
    logic [2:0] x;
    logic [1:0] y;
    logic [29:0] sym;
    sample(kind, req, fs, x, y, sym);
    exp_req = ((c % 20) < 8) && (((c / 20) % 8) < 4);
    check_eq($sformatf("k%0d c%0d req", kind, c), {31'd0, req}, {31'd0, exp_req});
    check_eq($sformatf("k%0d c%0d frame_start", kind, c), {31'd0, fs}, {31'd0, (c % 160) == 0});
    if (exp_req) begin
      check_eq($sformatf("k%0d c%0d x", kind, c), {29'd0, x}, c % 20);
      check_eq($sformatf("k%0d c%0d y", kind, c), {30'd0, y}, (c / 20) % 8);
    end
    check_eq($sformatf("k%0d c%0d tmds", kind, c), {2'b00, sym}, {2'b00, exp_sym(kind, c)});
  endtask

  task automatic drive_pixels();
    if_h.VIDDATA = prev_req[0] ? {8'hFF, 8'h00, 8'h00} : 24'h5AC35A;
    if_d.VIDDATA = prev_req[1] ? {8'hFF, 8'h00, 8'h00} : 24'h5AC35A;
    if_5.VIDDATA = prev_req[2] ? {5'h1F, 5'h10, 5'h00} : 15'h2AAA;
    prev_req[0] = if_h.PIXEL_REQ;
    prev_req[1] = if_d.PIXEL_REQ;
    prev_req[2] = if_5.PIXEL_REQ;
  endtask

  task automatic run_cycles(input int n);
    int last_fs, req_cnt;
    last_fs = -1;
    req_cnt = 0;
    for (int c = 0; c < n; c++) begin
      @(posedge clk);
      #1;
      drive_pixels();
      @(negedge clk);
      for (int k = 0; k < 3; k++) check_dut(k, c);
      if (if_h.FRAME_START) begin
        if (last_fs >= 0) begin
          check_eq($sformatf("fs_period c%0d", c), c - last_fs, 160);
          check_eq($sformatf("req_per_frame c%0d", c), req_cnt, 32);
        end
        last_fs = c;
        req_cnt = 0;
      end
      if (if_h.PIXEL_REQ) req_cnt++;
    end
  endtask

  task automatic reset_and_check(input string when);
    logic req, fs;
    logic [2:0] x;
    logic [1:0] y;
    logic [29:0] sym;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      sample(k, req, fs, x, y, sym);
      check_eq($sformatf("%s k%0d rst_req", when, k), {31'd0, req}, 32'd0);
      check_eq($sformatf("%s k%0d rst_fs", when, k), {31'd0, fs}, 32'd0);
      check_eq($sformatf("%s k%0d rst_x", when, k), {29'd0, x}, 32'd0);
      check_eq($sformatf("%s k%0d rst_y", when, k), {30'd0, y}, 32'd0);
      check_eq($sformatf("%s k%0d rst_tmds", when, k), {2'b00, sym}, {2'b00, {3{10'h354}}});
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int k = 0; k < 3; k++) prev_req[k] = 1'b0;
    if_h.VIDDATA = 24'h5AC35A;
    if_d.VIDDATA = 24'h5AC35A;
    if_5.VIDDATA = 15'h2AAA;
  endtask

  initial begin
    if_h.VIDDATA = 24'h5AC35A;
    if_d.VIDDATA = 24'h5AC35A;
    if_5.VIDDATA = 15'h2AAA;
    reset_and_check("power_on");
    // Stop in line 1 of the second frame while pixels are in flight
    run_cycles(183);
    reset_and_check("mid_line");
    run_cycles(350);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
